final_add_pipe: RTL

FINAL_ADD_PIPE -- requirements
Module: final_add_pipe

---
 rtl/final_add_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/final_add_pipe.sv
// -----------------------------------------------------------------------------
// final_add_pipe
//   Two-stage pipelined final adder for a multiplier compressor tree. The sum
//   row and the weight-aligned carry row are added in two halves: S1 adds the
//   low halves and keeps the upper halves, S2 adds the upper halves with the
//   S1 carry. Valid/ready handshakes on both sides give full throughput with
//   backpressure and no combinational path from row_a/row_b to prod.
//
//   Optional feature: define FINAL_ADD_CNT_EN to build a saturating 16-bit
//   counter of completed output transfers on txn_count. Without the macro
//   txn_count is tied to zero and no counter flops exist.
//
// Parameters
//   WIDTH      width of row_a, row_b and prod (even, >= 4)
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   row_a/row_b hold a valid operand pair
//   in_ready   pair is accepted this cycle
//   row_a      sum row
//   row_b      carry row, already weight-aligned
//   out_valid  prod/cout hold a valid result
//   out_ready  consumer takes the result this cycle
//   prod       (row_a + row_b) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   txn_count  completed output transfers (0 unless FINAL_ADD_CNT_EN)
// -----------------------------------------------------------------------------
module final_add_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] row_a,
  input  logic [WIDTH-1:0] row_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod,
  output logic             cout,
  output logic [15:0]      txn_count
);

  localparam int H = WIDTH / 2;

  // Stage 1: low-half sum, its carry, and the untouched upper halves.
  logic         r_s1_valid;
  logic [H-1:0] r_s1_lo_sum;
  logic         r_s1_lo_c;
  logic [H-1:0] r_s1_a_hi;
  logic [H-1:0] r_s1_b_hi;

  // Stage 2: complete result.
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_prod;
  logic             r_s2_cout;

  logic         w_out_xfer;
  logic         w_s2_adv;
  logic         w_s1_adv;
  logic [H:0]   w_lo_sum;
  logic [H:0]   w_hi_sum;

  // S2 may load whenever it is empty or its result leaves this cycle; S1 may
  // load whenever it is empty or S2 is taking its contents. in_ready therefore
  // never looks at in_valid, and a full pipe can accept and emit on one edge.
  assign w_out_xfer = r_s2_valid & out_ready;
  assign w_s2_adv   = ~r_s2_valid | w_out_xfer;
  assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
  assign in_ready   = w_s1_adv;

  // One extra bit on each half-add captures its carry.
  assign w_lo_sum = {1'b0, row_a[H-1:0]} + {1'b0, row_b[H-1:0]};
  assign w_hi_sum = {1'b0, r_s1_a_hi} + {1'b0, r_s1_b_hi} + {{H{1'b0}}, r_s1_lo_c};

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process order.
  // NOTE: data registers are reset along with the valid bits so prod/cout read
  // zero during reset rather than leftover values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_lo_sum <= '0;
      r_s1_lo_c   <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_lo_sum <= w_lo_sum[H-1:0];
      r_s1_lo_c   <= w_lo_sum[H];
      r_s1_a_hi   <= row_a[WIDTH-1:H];
      r_s1_b_hi   <= row_b[WIDTH-1:H];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_cout  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_prod  <= {w_hi_sum[H-1:0], r_s1_lo_sum};
      r_s2_cout  <= w_hi_sum[H];
    end
  end

  assign out_valid = r_s2_valid;
  assign prod      = r_s2_prod;
  assign cout      = r_s2_cout;

`ifdef FINAL_ADD_CNT_EN
  logic [15:0] r_txn_count;

  // Saturates so a long run never wraps back to a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_count <= '0;
    end else if (w_out_xfer && (r_txn_count != 16'hFFFF)) begin
      r_txn_count <= r_txn_count + 16'd1;
    end
  end

  assign txn_count = r_txn_count;
`else
  assign txn_count = '0;
`endif

endmodule
